btn_debouncer: RTL



---
 rtl/btn_debouncer.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/btn_debouncer.sv
// Debounces a raw asynchronous input: 2-flop sync, stable-time filter FSM, level + rise/fall strobes.
// Level and strobes change STABLE_CYCLES+1 edges after the first sample of a stable new value; no backpressure.
module btn_debouncer #(
  parameter int STABLE_CYCLES = 1000,
  parameter int CNT_W         = 16,
  parameter int GLITCH_W      = 8
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_btn,
  output logic                o_level,
  output logic                o_rise,
  output logic                o_fall,
  output logic [GLITCH_W-1:0] o_glitch_cnt
);

  typedef enum logic [1:0] {
    ST_LOW      = 2'd0,
    ST_CHK_HIGH = 2'd1,
    ST_HIGH     = 2'd2,
    ST_CHK_LOW  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0]    CNT_LAST   = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]    CNT_ONE    = CNT_W'(1);
  localparam logic [GLITCH_W-1:0] GLITCH_ONE = GLITCH_W'(1);

  logic                s1_q, s2_q;
  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                level_q, level_d;
  logic                rise_q, rise_d;
  logic                fall_q, fall_d;
  logic [GLITCH_W-1:0] glitch_q, glitch_d;
  logic                term_cnt;
  logic                abort;

  assign term_cnt = (cnt_q == CNT_LAST);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      state_q  <= ST_LOW;
      cnt_q    <= '0;
      level_q  <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      glitch_q <= '0;
    end else begin
      s1_q     <= i_btn;
      s2_q     <= s1_q;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      level_q  <= level_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      glitch_q <= glitch_d;
    end
  end

  // A bounce back to the old value takes priority over the terminal count.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_LOW: begin
        if (s2_q) begin
          state_d = ST_CHK_HIGH;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d   = '0;
        end
      end
      ST_CHK_HIGH: begin
        if (!s2_q) begin
          state_d = ST_LOW;
          cnt_d   = '0;
        end else if (term_cnt) begin
          state_d = ST_HIGH;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      ST_HIGH: begin
        if (!s2_q) begin
          state_d = ST_CHK_LOW;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d   = '0;
        end
      end
      ST_CHK_LOW: begin
        if (s2_q) begin
          state_d = ST_HIGH;
          cnt_d   = '0;
        end else if (term_cnt) begin
          state_d = ST_LOW;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
    endcase
  end

  always_comb begin
    level_d  = level_q;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    glitch_d = glitch_q;
    abort    = 1'b0;
    unique case (state_q)
      ST_CHK_HIGH: begin
        if (!s2_q) begin
          abort = 1'b1;
        end else if (term_cnt) begin
          level_d = 1'b1;
          rise_d  = 1'b1;
        end
      end
      ST_CHK_LOW: begin
        if (s2_q) begin
          abort = 1'b1;
        end else if (term_cnt) begin
          level_d = 1'b0;
          fall_d  = 1'b1;
        end
      end
      default: begin
        abort = 1'b0;
      end
    endcase
    // Saturate rather than wrap so a noisy input stays visible.
    if (abort && (glitch_q != '1)) begin
      glitch_d = glitch_q + GLITCH_ONE;
    end
  end

  assign o_level      = level_q;
  assign o_rise       = rise_q;
  assign o_fall       = fall_q;
  assign o_glitch_cnt = glitch_q;

endmodule
